neuron_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the 16-bit carry-lookahead adder. It computes one neuron pre-activation per transaction: it loads a bias, then sums exactly `N_TERMS` signed 16-bit streamed terms (weighted products) into a saturating accumulator. The result is presented on a valid/ready output, optionally through ReLU. It sits between the multiplier array and the next autoencoder layer's input buffer.

---
 rtl/autoenc_pkg.sv | 15 +
 rtl/cla4.sv | 29 ++
 rtl/sat_add16.sv | 36 +++
 rtl/neuron_accumulator.sv | 103 ++++++++++
 tb/tb_neuron_accumulator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/autoenc_pkg.sv
// Shared constants and types for the autoencoder datapath blocks.
package autoenc_pkg;

    localparam int DATA_W = 16;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } nacc_state_e;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; slices chain through cin/cout.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/sat_add16.sv
// Combinational 16-bit signed saturating adder built from four cla4 slices.
module sat_add16
    import autoenc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    logic [DATA_W-1:0] raw;
    logic [4:0]        carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        cla4 u_cla4 (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (carry[i]),
            .sum  (raw[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);

    // On overflow both operands share a sign; a carry out means both were negative.
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = carry[4] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Bias-loaded saturating accumulator producing one neuron pre-activation per transaction.
// Optional ReLU on the result when NEURON_ACC_RELU_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for start; no term or result handshakes
//  ACC   | accepting N_TERMS terms into the accumulator
//  DONE  | result held on out_data until out_ready
module neuron_accumulator #(
    parameter int N_TERMS = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ovf,
    output logic              busy
);

    import autoenc_pkg::*;

    localparam int               CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    nacc_state_e       state_q;
    nacc_state_e       state_d;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [DATA_W-1:0] out_q;

    logic [DATA_W-1:0] acc_sum;
    logic              add_ovf;
    logic [DATA_W-1:0] act_data;
    logic              term_accept;
    logic              last_term;

    sat_add16 u_sat_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (acc_sum),
        .ovf (add_ovf)
    );

`ifdef NEURON_ACC_RELU_EN
    assign act_data = acc_sum[DATA_W-1] ? '0 : acc_sum;
`else
    assign act_data = acc_sum;
`endif

    assign term_accept = (state_q == ACC) && in_valid;
    assign last_term   = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)                    state_d = ACC;
            ACC:  if (term_accept && last_term) state_d = DONE;
            DONE: if (out_ready)                state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                acc_q <= bias;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (term_accept) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CNT_W'(1);
                if (add_ovf) begin
                    ovf_q <= 1'b1;
                end
                // Result register is loaded only on the final term so it holds through DONE.
                if (last_term) begin
                    out_q <= act_data;
                end
            end
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: directed scenarios plus randomized transactions
// compared every cycle against an integer-arithmetic reference model.
module tb_neuron_accumulator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ovf;
    logic        busy;

    int tests = 0;
    int fails = 0;

    neuron_accumulator #(.N_TERMS(N), .DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = summing, 2 = result pending.
    int          m_phase = 0;
    int          m_acc   = 0;
    int          m_cnt   = 0;
    bit          m_ovf   = 1'b0;
    logic [15:0] m_out   = 16'h0000;

    function automatic logic [15:0] act_fn(input int v);
        logic [15:0] r;
        r = 16'(v);
`ifdef NEURON_ACC_RELU_EN
        if (v < 0) r = 16'h0000;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_out = 16'h0000;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_acc = $signed(bias); m_cnt = 0; m_ovf = 1'b0; m_phase = 1;
                end
                1: if (in_valid) begin
                    m_acc = m_acc + $signed(in_data);
                    if (m_acc > 32767)       begin m_acc = 32767;  m_ovf = 1'b1; end
                    else if (m_acc < -32768) begin m_acc = -32768; m_ovf = 1'b1; end
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_phase = 2;
                        m_out   = act_fn(m_acc);
                    end
                end
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_in_ready",  in_ready,  m_phase == 1);
            chk("cyc_out_valid", out_valid, m_phase == 2);
            chk("cyc_busy",      busy,      m_phase != 0);
            chk("cyc_ovf",       ovf,       m_ovf);
            if (m_phase == 2) chk("cyc_out_data", out_data, m_out);
        end
    end

    task automatic do_start(input logic [15:0] b);
        start = 1'b1; bias = b;
        @(posedge clk); #1;
        start = 1'b0; bias = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'($urandom);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"},  out_data,  16'h0000);
        chk({tag, "_ovf"},       ovf,       1'b0);
        chk({tag, "_busy"},      busy,      1'b0);
    endtask

    function automatic logic [15:0] rand_term();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom_range(0, 40));
            1:       return 16'(-$urandom_range(0, 40));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gap_terms [4];
        bit          gap_pat   [7];
        int          k;

        rst_n = 1'b0; start = 1'b0; bias = 16'h0000;
        in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Basic sum
        do_start(16'h0010);
        chk("basic_busy", busy, 1'b1);
        chk("basic_in_ready", in_ready, 1'b1);
        send(16'h0001); send(16'h0002); send(16'h0003);
        chk("basic_not_yet_valid", out_valid, 1'b0);
        send(16'h0004);
        chk("basic_out_valid", out_valid, 1'b1);
        chk("basic_out_data", out_data, 16'h001A);
        chk("basic_ovf", ovf, 1'b0);
        handshake();
        chk("basic_hs_out_valid", out_valid, 1'b0);
        chk("basic_hs_busy", busy, 1'b0);

        // Positive saturation
        do_start(16'h7F00);
        repeat (4) send(16'h0100);
        chk("pos_out_data", out_data, 16'h7FFF);
        chk("pos_ovf", ovf, 1'b1);
        handshake();

        // Back-to-back: start in the cycle right after the handshake
        do_start(16'hFFFF);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_ovf_cleared", ovf, 1'b0);
        repeat (4) send(16'h0001);
        chk("b2b_out_data", out_data, 16'h0003);
        chk("b2b_ovf", ovf, 1'b0);
        handshake();

        // Negative saturation
        do_start(16'h8100);
        repeat (4) send(16'hFF00);
`ifdef NEURON_ACC_RELU_EN
        chk("neg_out_data", out_data, 16'h0000);
`else
        chk("neg_out_data", out_data, 16'h8000);
`endif
        chk("neg_ovf", ovf, 1'b1);
        handshake();

        // Gaps and backpressure
        gap_terms = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
        gap_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        k = 0;
        do_start(16'h0000);
        for (int i = 0; i < 7; i++) begin
            if (gap_pat[i]) begin
                send(gap_terms[k]);
                k++;
            end else begin
                in_valid = 1'b0; in_data = 16'h1234;
                idle(1);
            end
        end
        chk("gap_out_valid", out_valid, 1'b1);
        chk("gap_out_data", out_data, 16'h001A);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); bias = 16'h7777;
            idle(1);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, 16'h001A);
            chk("bp_busy", busy, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        start = 1'b0;
        handshake();
        idle(2);
        chk("bp_start_not_queued", busy, 1'b0);

        // Reset mid-accumulation
        do_start(16'h7FFF);
        send(16'h0001); send(16'h0001);
        chk("mid_ovf_before_reset", ovf, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        do_start(16'h0000);
        repeat (4) send(16'h0001);
        chk("post_rst_out_data", out_data, 16'h0004);
        chk("post_rst_ovf", ovf, 1'b0);
        handshake();

        // Randomized transactions with gaps, ignored start pulses and backpressure
        for (int t = 0; t < 60; t++) begin
            idle($urandom_range(0, 2));
            do_start(rand_term());
            for (int c = 0; c < 200 && in_ready === 1'b1; c++) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = rand_term();
                start    = ($urandom_range(0, 4) == 0);
                bias     = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; start = 1'b0;
            chk("rnd_reached_done", out_valid, 1'b1);
            for (int w = $urandom_range(0, 4); w > 0; w--) begin
                start    = ($urandom_range(0, 1) != 0);
                in_valid = ($urandom_range(0, 1) != 0);
                in_data  = 16'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0; in_valid = 1'b0;
            handshake();
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
